// File: rtl/terc4_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | terc4_decoder: TERC4 data-island symbol decoder with lock tracking;         |
// | optional saturating error counter enabled by `define TERC4_ERRCNT_EN.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module terc4_decoder #(
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4
`ifdef TERC4_ERRCNT_EN
  , parameter int ERRCNT_W   = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sym_valid,
  input  logic [9:0] i_sym,
  output logic [3:0] o_data,
  output logic       o_data_valid,
  output logic       o_code_err,
  output logic       o_locked
`ifdef TERC4_ERRCNT_EN
  , input  logic                i_err_clear
  , output logic [ERRCNT_W-1:0] o_err_count
`endif
);

  localparam int c_MAX_CNT = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
  localparam logic [c_CNT_W-1:0] c_LOCK_LAST   = c_CNT_W'(LOCK_COUNT - 1);
  localparam logic [c_CNT_W-1:0] c_UNLOCK_LAST = c_CNT_W'(UNLOCK_COUNT - 1);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  logic [9:0]         r_sym;
  logic               r_sym_vld;
  logic [3:0]         r_data;
  logic               r_data_valid;
  logic               r_code_err;
  logic [3:0]         w_nib;
  logic               w_hit;
  state_t             r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_good_cnt, w_good_nxt;
  logic [c_CNT_W-1:0] r_bad_cnt, w_bad_nxt;

  always_comb begin
    w_nib = 4'h0;
    w_hit = 1'b1;
    case (r_sym)
      10'b1010011100: w_nib = 4'h0;
      10'b1001100011: w_nib = 4'h1;
      10'b1011100100: w_nib = 4'h2;
      10'b1011100010: w_nib = 4'h3;
      10'b0101110001: w_nib = 4'h4;
      10'b0100011110: w_nib = 4'h5;
      10'b0110001110: w_nib = 4'h6;
      10'b0100111100: w_nib = 4'h7;
      10'b1011001100: w_nib = 4'h8;
      10'b0100111001: w_nib = 4'h9;
      10'b0110011100: w_nib = 4'hA;
      10'b1011000110: w_nib = 4'hB;
      10'b1010001110: w_nib = 4'hC;
      10'b1001110001: w_nib = 4'hD;
      10'b0101100011: w_nib = 4'hE;
      10'b1011000011: w_nib = 4'hF;
      default:        w_hit = 1'b0;
    endcase
  end

  // Two-stage pipeline; data holds its last value across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym        <= '0;
      r_sym_vld    <= 1'b0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_code_err   <= 1'b0;
    end else begin
      r_sym        <= i_sym;
      r_sym_vld    <= i_sym_valid;
      r_data_valid <= r_sym_vld;
      r_code_err   <= r_sym_vld & ~w_hit;
      if (r_sym_vld) begin
        r_data <= w_nib;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SEARCH;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_bad_cnt  <= w_bad_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    if (r_data_valid) begin
      case (r_state)
        ST_SEARCH: begin
          if (r_code_err) begin
            w_good_nxt = '0;
          end else if (r_good_cnt == c_LOCK_LAST) begin
            w_state_nxt = ST_LOCKED;
            w_good_nxt  = '0;
          end else begin
            w_good_nxt = r_good_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!r_code_err) begin
            w_bad_nxt = '0;
          end else if (r_bad_cnt == c_UNLOCK_LAST) begin
            w_state_nxt = ST_SEARCH;
            w_bad_nxt   = '0;
          end else begin
            w_bad_nxt = r_bad_cnt + 1'b1;
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end
  end

`ifdef TERC4_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (i_err_clear) begin
      r_err_cnt <= '0;
    end else if (r_code_err && (r_err_cnt != {ERRCNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_err_count = r_err_cnt;
`endif

  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_code_err   = r_code_err;
  assign o_locked     = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_terc4_decoder.sv
`default_nettype none
// Scoreboard bench for terc4_decoder: expected nibble/error pushed at issue,
// popped and compared by an independent monitor whenever data_valid is high.
module tb_terc4_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_sym_valid;
  logic [9:0] i_sym;
  logic [3:0] o_data;
  logic       o_data_valid;
  logic       o_code_err;
  logic       o_locked;
`ifdef TERC4_ERRCNT_EN
  logic       i_err_clear;
  logic [3:0] o_err_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] sb[$];

  logic [9:0] tbl [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  always #5 clk = ~clk;

  terc4_decoder #(
    .LOCK_COUNT   (8),
    .UNLOCK_COUNT (4)
`ifdef TERC4_ERRCNT_EN
    , .ERRCNT_W   (4)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sym_valid  (i_sym_valid),
    .i_sym        (i_sym),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_code_err   (o_code_err),
    .o_locked     (o_locked)
`ifdef TERC4_ERRCNT_EN
    , .i_err_clear (i_err_clear)
    , .o_err_count (o_err_count)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {code_err, nibble} straight from the TERC4 table.
  function automatic logic [4:0] expect_of(input logic [9:0] s);
    for (int k = 0; k < 16; k++) begin
      if (tbl[k] == s) return {1'b0, 4'(k)};
    end
    return 5'b1_0000;
  endfunction

  task automatic send(input logic [9:0] s);
    @(negedge clk);
    i_sym       = s;
    i_sym_valid = 1'b1;
    sb.push_back(expect_of(s));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_sym_valid = 1'b0;
      i_sym       = ~i_sym;
      @(posedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    i_sym_valid = 1'b0;
    rst_n       = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (o_data_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {15'd0, o_data_valid}, 16'd0);
        end else begin
          e = sb.pop_front();
          chk("data", {12'd0, o_data}, {12'd0, e[3:0]});
          chk("code_err", {15'd0, o_code_err}, {15'd0, e[4]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    i_sym_valid = 1'b0;
    i_sym       = '0;
`ifdef TERC4_ERRCNT_EN
    i_err_clear = 1'b0;
`endif
    // Reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      i_sym       = tbl[i];
      i_sym_valid = i[0];
    end
    @(posedge clk);
    #1;
    chk("rst_data", {12'd0, o_data}, 16'd0);
    chk("rst_valid", {15'd0, o_data_valid}, 16'd0);
    chk("rst_code_err", {15'd0, o_code_err}, 16'd0);
    chk("rst_locked", {15'd0, o_locked}, 16'd0);
`ifdef TERC4_ERRCNT_EN
    chk("rst_err_count", {12'd0, o_err_count}, 16'd0);
`endif
    @(negedge clk);
    i_sym_valid = 1'b0;
    rst_n       = 1'b1;

    // All 16 table symbols back-to-back
    for (int i = 0; i < 16; i++) send(tbl[i]);
    idle(3);
    #1;
    chk("hold_data", {12'd0, o_data}, 16'h000F);
    chk("idle_valid", {15'd0, o_data_valid}, 16'd0);

    // Out-of-table symbols
    send(10'h000);
    send(10'h3FF);
    idle(3);
`ifdef TERC4_ERRCNT_EN
    #1;
    chk("err_count_2", {12'd0, o_err_count}, 16'd2);
`endif

    // Lock acquire / hold / loss
    pulse_reset();
    for (int i = 0; i < 7; i++) send(tbl[i]);
    idle(3);
    #1;
    chk("locked_after_7", {15'd0, o_locked}, 16'd0);
    send(tbl[7]);
    idle(1);
    #1;
    chk("locked_early", {15'd0, o_locked}, 16'd0);
    idle(1);
    #1;
    chk("locked_after_8", {15'd0, o_locked}, 16'd1);
    send(10'h000); send(10'h155); send(10'h2AA); send(tbl[3]);
    idle(3);
    #1;
    chk("locked_3bad_1good", {15'd0, o_locked}, 16'd1);
    send(10'h001); send(10'h002); send(10'h003); send(10'h004);
    idle(1);
    #1;
    chk("unlock_early", {15'd0, o_locked}, 16'd1);
    idle(1);
    #1;
    chk("unlocked_after_4bad", {15'd0, o_locked}, 16'd0);

    // Saturation and clear priority
    for (int i = 0; i < 20; i++) send(10'(i * 3 + 1));
    idle(3);
`ifdef TERC4_ERRCNT_EN
    #1;
    chk("err_count_sat", {12'd0, o_err_count}, 16'd15);
    send(10'h3FF);
    idle(1);
    @(negedge clk);
    i_err_clear = 1'b1;
    @(posedge clk);
    #1;
    chk("err_clear", {12'd0, o_err_count}, 16'd0);
    i_err_clear = 1'b0;
    idle(2);
`endif

    // Async reset while locked with a symbol in flight
    pulse_reset();
    for (int i = 0; i < 8; i++) send(tbl[i + 8]);
    idle(2);
    #1;
    chk("relock_pre", {15'd0, o_locked}, 16'd1);
    send(tbl[5]);
    #2;
    rst_n       = 1'b0;
    i_sym_valid = 1'b0;
    sb.delete();
    #1;
    chk("async_locked", {15'd0, o_locked}, 16'd0);
    chk("async_data", {12'd0, o_data}, 16'd0);
    chk("async_valid", {15'd0, o_data_valid}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    for (int i = 0; i < 7; i++) send(tbl[i]);
    idle(3);
    #1;
    chk("relock_after_7", {15'd0, o_locked}, 16'd0);
    send(tbl[9]);
    idle(2);
    #1;
    chk("relock_after_8", {15'd0, o_locked}, 16'd1);
    idle(2);
    chk("sb_drained", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
